// File: rtl/dsram_responder.sv
// Data-side SRAM responder: word-organised storage with byte-lane writes,
// registered read data and an optional wait-state FSM that drives stallreq_mem.
module dsram_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              stallreq_mem
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    logic [31:0]       mem_q [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [3:0]        wen_q, wen_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q;

    logic              do_access;
    logic [ADDR_W-1:0] acc_idx;
    logic [3:0]        acc_wen;
    logic [31:0]       acc_wdata;

    logic [ADDR_W-1:0] in_idx;
    logic              unused_addr_bits;

    // Byte offset and bits above the word index are ignored, so addresses alias.
    assign in_idx           = data_sram_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_W+2]};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        do_access    = 1'b0;
        acc_idx      = idx_q;
        acc_wen      = wen_q;
        acc_wdata    = wdata_q;
        stallreq_mem = 1'b0;

        if (WAIT == 0) begin
            do_access = data_sram_en;
            acc_idx   = in_idx;
            acc_wen   = data_sram_wen;
            acc_wdata = data_sram_wdata;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_sram_en) begin
                        stallreq_mem = 1'b1;
                        idx_d        = in_idx;
                        wen_d        = data_sram_wen;
                        wdata_d      = data_sram_wdata;
                        cnt_d        = 4'(WAIT - 1);
                        state_d      = BUSY;
                    end
                end
                BUSY: begin
                    // The access is performed from the latched copy, not the live inputs.
                    if (cnt_q != 4'd0) begin
                        stallreq_mem = 1'b1;
                        cnt_d        = cnt_q - 4'd1;
                    end else begin
                        do_access = 1'b1;
                        state_d   = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wen_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            if (do_access && (acc_wen == 4'd0)) begin
                rdata_q <= mem_q[acc_idx];
            end
        end
    end

    // Storage is never cleared; reset only blocks a write from committing.
    always_ff @(posedge clk) begin
        if (rst && do_access) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign data_sram_rdata = rdata_q;

endmodule

// File: tb/tb_dsram_responder.sv
// Scoreboard bench for dsram_responder: three instances (WAIT = 0, 2, 3) driven
// with directed and random accesses against a word/byte memory model.
module tb_dsram_responder;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } expT;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   doneCnt = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mergeBytes(input logic [31:0] old, input logic [31:0] nw,
                                               input logic [3:0] lanes);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    function automatic int idxOf(input logic [31:0] a);
        return int'((a >> 2) & 32'hFFF);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : blk
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;

        logic        rst;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        stall;

        expT         rdQ[$];
        expT         stQ[$];
        logic [31:0] model [int];
        int          startCyc = 32'h7FFF_FFFF;

        dsram_responder #(.ADDR_W(12), .WAIT(W)) dut (
            .clk            (clk),
            .rst            (rst),
            .data_sram_en   (en),
            .data_sram_wen  (wen),
            .data_sram_addr (addr),
            .data_sram_wdata(wdata),
            .data_sram_rdata(rdata),
            .stallreq_mem   (stall)
        );

        function automatic void pushSt(input int c, input logic v);
            expT e;
            e.cyc = c;
            e.val = {31'd0, v};
            stQ.push_back(e);
        endfunction

        function automatic void pushRd(input int c, input logic [31:0] v);
            expT e;
            e.cyc = c;
            e.val = v;
            rdQ.push_back(e);
        endfunction

        function automatic logic [31:0] mkAddr(input int idx);
            return ($urandom & 32'hFFFF_C000) | (32'(idx) << 2) | ($urandom & 32'h3);
        endfunction

        // One complete access: request held for W+1 cycles, inputs scrambled once latched.
        task automatic applyStimulus(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
            int c;
            int ix;
            @(posedge clk); #1;
            en = 1'b1; wen = w; addr = a; wdata = d;
            c = cyc;
            pushSt(c, W > 0);
            for (int k = 1; k <= W; k++) begin
                @(posedge clk); #1;
                wen = 4'($urandom); addr = $urandom; wdata = $urandom;
                pushSt(cyc, k < W);
            end
            ix = idxOf(a);
            if (w == 4'd0) pushRd(c + W + 1, model[ix]);
            else if (model.exists(ix)) model[ix] = mergeBytes(model[ix], d, w);
            else model[ix] = d;
        endtask

        task automatic idle(input int n);
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                en = 1'b0; wen = 4'($urandom); addr = $urandom; wdata = $urandom;
                pushSt(cyc, 1'b0);
            end
        endtask

        task automatic idleReset();
            @(posedge clk); #1;
            en = 1'b0; rst = 1'b0;
            pushSt(cyc, 1'b0);
            @(posedge clk); #1;
            rst = 1'b1;
            pushSt(cyc, 1'b0);
            pushRd(cyc, 32'd0);
        endtask

        // Reset one cycle into a write: the write must be dropped.
        task automatic resetDuringBusy(input logic [31:0] a, input logic [31:0] d);
            @(posedge clk); #1;
            en = 1'b1; wen = 4'hF; addr = a; wdata = d;
            pushSt(cyc, 1'b1);
            @(posedge clk); #1;
            en = 1'b0; rst = 1'b0;
            pushSt(cyc, 1'b1);
            @(posedge clk); #1;
            rst = 1'b1;
            pushSt(cyc, 1'b0);
            pushRd(cyc, 32'd0);
        endtask

        initial begin
            int keys[$];
            int r;
            int ix;
            rst = 1'b0; en = 1'b0; wen = 4'd0; addr = 32'd0; wdata = 32'd0;
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b1;
            startCyc = cyc;
            pushSt(cyc, 1'b0);

            applyStimulus(4'hF, 32'h10, 32'hDEADBEEF);
            applyStimulus(4'h0, 32'h10, 32'h0);
            applyStimulus(4'hF, 32'h20, 32'h11223344);
            applyStimulus(4'b0100, 32'h20, 32'h00AA0000);
            applyStimulus(4'h0, 32'h20, 32'h0);
            applyStimulus(4'h0, 32'h23, 32'h0);
            applyStimulus(4'hF, 32'h40, 32'h12345678);
            idle(2);
            applyStimulus(4'h0, 32'h40, 32'h0);
            applyStimulus(4'h0, 32'h10, 32'h0);
            applyStimulus(4'hF, 32'h0000_4004, 32'h5A5A5A5A);
            applyStimulus(4'h0, 32'h0000_0004, 32'h0);
            idleReset();
            applyStimulus(4'h0, 32'h20, 32'h0);
            if (W >= 2) begin
                applyStimulus(4'hF, 32'h80, 32'h0BADF00D);
                applyStimulus(4'h0, 32'h40, 32'h0);
                resetDuringBusy(32'h80, 32'hCAFEF00D);
                applyStimulus(4'h0, 32'h80, 32'h0);
            end

            keys = '{0, 1, 2, 3, 4, 5, 6, 7, 4095};
            foreach (keys[k]) applyStimulus(4'hF, mkAddr(keys[k]), $urandom);
            for (int n = 0; n < 150; n++) begin
                r  = int'($urandom_range(0, 9));
                ix = keys[$urandom_range(0, keys.size() - 1)];
                if (r < 2) idle(int'($urandom_range(1, 3)));
                else if (r < 5) applyStimulus(4'h0, mkAddr(ix), $urandom);
                else if (r < 8) applyStimulus(4'($urandom_range(1, 15)), mkAddr(ix), $urandom);
                else applyStimulus(4'hF, mkAddr(ix), $urandom);
            end
            idle(W + 3);
            doneCnt++;
        end

        initial begin
            logic [31:0] expRd;
            expT         e;
            expRd = 32'd0;
            forever begin
                @(negedge clk);
                if (cyc >= startCyc) begin
                    while (rdQ.size() > 0 && rdQ[0].cyc <= cyc) begin
                        e = rdQ.pop_front();
                        expRd = e.val;
                    end
                    checkOutput($sformatf("W%0d rdata cyc%0d", W, cyc), rdata, expRd);
                    while (stQ.size() > 0 && stQ[0].cyc < cyc) void'(stQ.pop_front());
                    if (stQ.size() > 0 && stQ[0].cyc == cyc) begin
                        e = stQ.pop_front();
                        checkOutput($sformatf("W%0d stall cyc%0d", W, cyc), {31'd0, stall}, e.val);
                    end
                end
            end
        end
    end

    initial begin
        for (int t = 0; t < 40000 && doneCnt < 3; t++) @(posedge clk);
        repeat (2) @(posedge clk);
        checkOutput("drivers finished", 32'(doneCnt), 32'd3);
        checkOutput("W0 rd queue drained", 32'(blk[0].rdQ.size()), 32'd0);
        checkOutput("W2 rd queue drained", 32'(blk[1].rdQ.size()), 32'd0);
        checkOutput("W3 rd queue drained", 32'(blk[2].rdQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dsram_responder.md
Name: dsram_responder

Overview:
- Data-side SRAM responder: the slave end of the data_sram_* interface that the EX stage drives and the MEM stage reads back on data_sram_rdata.
- Word-organised storage with byte-lane writes and registered read data.
- A parameterised number of wait states emulates slow memory. While an access is outstanding, the block raises a stall request into the CTRL stall logic.
- Sits outside the CPU core, on the data port; used as the on-chip data RAM and as the bench memory for the pipeline.

Parameters:
- ADDR_W, 12, word-index width; storage depth is 2**ADDR_W 32-bit words.
- WAIT, 0, extra wait cycles per access (legal range 0..15); 0 means single-cycle memory that never stalls.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
- data_sram_en  input  1  access request valid this cycle.
- data_sram_wen  input  4  byte-lane write enables; 4'b0000 = read, otherwise write; bit i writes bits [8i+7:8i].
- data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2].
- data_sram_wdata  input  32  write data, lane-aligned.
- data_sram_rdata  output  32  read data, registered.
- stallreq_mem  output  1  request to freeze PC..EX while the access is pending; combinational.

Behaviour:
- Reset (rst=0 at an edge):
  - state<=IDLE, cnt<=0, latched request cleared, data_sram_rdata<=0; stallreq_mem is 0 after reset.
  - Storage array is not reset; contents are unchanged.
  - Reset during BUSY abandons the access: a pending write is not committed and rdata is not updated.
- Addressing:
  - addr[1:0] and addr[31:ADDR_W+2] are ignored, so upper addresses alias and wrap modulo the depth.
  - Lane selection comes from wen only.
- en=0: no access, regardless of wen/addr/wdata; rdata holds.
- WAIT=0 (state stays IDLE):
  - Request presented in cycle N is performed at the end of cycle N.
  - Read: rdata<=mem[idx], visible in cycle N+1.
  - Write: enabled lanes updated at the end of cycle N; rdata holds its previous value.
  - A read in N+1 of the index written in N returns the new data.
  - stallreq_mem is constantly 0.
- WAIT>0, two-state FSM IDLE/BUSY:
  - IDLE & en: latch addr/wen/wdata; cnt<=WAIT-1; ->BUSY. No memory action at this edge.
  - BUSY & cnt!=0: cnt<=cnt-1; inputs are ignored (the pipeline holds them stable).
  - BUSY & cnt==0: perform the latched access at this edge (read -> rdata, write -> lanes); ->IDLE.
  - stallreq_mem = (IDLE & en) | (BUSY & cnt!=0).
  - Consequence: stall is high in cycles N..N+WAIT-1, low in N+WAIT; the access completes at the end of N+WAIT; read data is visible in N+WAIT+1. Total access = WAIT+1 cycles.
  - The still-held request in the completion cycle is not re-accepted, because state is BUSY.
  - A new request in cycle N+WAIT+1 is accepted normally; back-to-back accesses have no bubble beyond WAIT.
- Written lanes outside wen keep their old bytes. wen=4'b1111 is a full-word write.
- rdata changes only on read completion or reset; it holds across writes and idle cycles.

Test Plan:
- WAIT=0: write addr 0x10 data 0xDEADBEEF wen 1111, next cycle read 0x10 -> rdata=0xDEADBEEF in the cycle after the read; stallreq_mem never 1.
- WAIT=0 byte lanes: preload 0x11223344 at 0x20, write wen 0100 wdata 0x00AA0000, read 0x20 -> 0x11AA3344. Then read 0x23 -> same word (addr[1:0] ignored).
- WAIT=2: read 0x40 (holding 0x12345678) presented in cycle N -> stallreq_mem 1 in N,N+1 and 0 in N+2; rdata=0x12345678 in N+3; rdata unchanged before N+3.
- WAIT=2, en held high through completion then dropped -> exactly one access, FSM back in IDLE. A second read presented in N+3 -> stall in N+3,N+4.
- WAIT=3: write 0xCAFEF00D to 0x80, assert rst=0 in cycle N+1 -> after reset the read of 0x80 returns the old value; rdata=0, stallreq_mem=0 right after reset.
- ADDR_W=12 alias: write 0x5A5A5A5A to 0x0000_4004, read 0x0000_0004 -> 0x5A5A5A5A.
